// File: rtl/cpu0_io_pkg.sv
// Shared constants for the cpu0 memory-mapped I/O responder: bus size codes,
// register offsets, STATUS/CTRL bit positions and staging FSM states.
package cpu0_io_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_INT16 = 2'b01;
  localparam logic [1:0] SZ_INT24 = 2'b10;
  localparam logic [1:0] SZ_INT32 = 2'b11;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int STAT_TXBUSY  = 0;
  localparam int STAT_TXEMPTY = 1;
  localparam int STAT_RXAVAIL = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_RXOVF   = 4;
  localparam int STAT_RXCNT   = 8;

  localparam int CTRL_RXIE = 0;
  localparam int CTRL_TXIE = 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Byte lane idx of a staged store word, lane 0 being bits [7:0].
  function automatic logic [7:0] stage_byte(input logic [31:0] word, input logic [1:0] idx);
    return 8'(word >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/cpu0_io_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push when full and pop
// when empty are ignored, so callers may drive requests unconditionally.
module cpu0_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/cpu0_io_responder.sv
// cpu0 bus target for the I/O window: stores become a TX byte stream, an RX
// byte stream is buffered for loads, and a level irq reports RX/TX events.
module cpu0_io_responder
  import cpu0_io_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h0008_0000,
  parameter int          TX_DEPTH = 16,
  parameter int          RX_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m_en,
  input  logic        m_rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  logic            w_sel, w_start, w_end, w_wrStart;
  logic            r_accD, r_accDataRd;
  logic [0:0]      r_state;
  logic [1:0]      r_idx, r_size;
  logic [31:0]     r_stage;
  logic            r_ovf, r_rxOvf, r_irq;
  logic [1:0]      r_ctrl;
  logic [7:0]      w_curByte;
  logic            w_skip, w_advance, w_last;
  logic            w_txPush, w_txPop, w_txFull, w_txEmpty;
  logic [TXCW-1:0] w_unusedTxCount;
  logic            w_rxPush, w_rxPop, w_rxFull, w_rxEmpty;
  logic [RXCW-1:0] w_rxCount;
  logic [7:0]      w_rxHead;
  logic            w_txBusy, w_txIdleEmpty;
  logic [31:0]     w_status, w_rdData;

  assign w_sel     = m_en && (abus[31:4] == BASE[31:4]);
  assign w_start   = w_sel && !r_accD;
  assign w_end     = !w_sel && r_accD;
  assign w_wrStart = w_start && !m_rw;

  // The RX pop waits for the access end, so remember whether it was a DATA load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_accD      <= 1'b0;
      r_accDataRd <= 1'b0;
    end else begin
      r_accD <= w_sel;
      if (w_start) r_accDataRd <= m_rw && (abus[3:0] == OFF_DATA);
    end
  end

  assign w_curByte = stage_byte(r_stage, r_idx);
  assign w_skip    = (r_size != SZ_BYTE) && (w_curByte == 8'h00);
  assign w_last    = (r_idx == r_size);
  assign w_advance = (r_state == ST_DRAIN) && (w_skip || !w_txFull);
  assign w_txPush  = (r_state == ST_DRAIN) && !w_skip && !w_txFull;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_size  <= SZ_BYTE;
      r_stage <= 32'h0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_advance) begin
        if (w_last) r_state <= ST_IDLE;
        else        r_idx   <= r_idx + 2'd1;
      end
      if (w_wrStart && abus[3:0] == OFF_DATA) begin
        if (r_state == ST_IDLE) begin
          r_state <= ST_DRAIN;
          r_idx   <= 2'd0;
          r_size  <= m_size;
          r_stage <= dbus_in;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (w_wrStart && abus[3:0] == OFF_STATUS && dbus_in[STAT_OVF]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ctrl  <= 2'b00;
      r_rxOvf <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wrStart && abus[3:0] == OFF_CTRL) r_ctrl <= dbus_in[1:0];
      if (rx_valid && w_rxFull)
        r_rxOvf <= 1'b1;
      else if (w_wrStart && abus[3:0] == OFF_STATUS && dbus_in[STAT_RXOVF])
        r_rxOvf <= 1'b0;
      r_irq <= (r_ctrl[CTRL_RXIE] && !w_rxEmpty) || (r_ctrl[CTRL_TXIE] && w_txIdleEmpty);
    end
  end

  assign w_txPop  = !w_txEmpty && tx_ready;
  assign w_rxPush = rx_valid && !w_rxFull;
  assign w_rxPop  = w_end && r_accDataRd;

  cpu0_io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txFifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_txPush),
    .i_pop   (w_txPop),
    .i_data  (w_curByte),
    .o_full  (w_txFull),
    .o_empty (w_txEmpty),
    .o_count (w_unusedTxCount),
    .o_head  (tx_data)
  );

  cpu0_io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rxFifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_rxPush),
    .i_pop   (w_rxPop),
    .i_data  (rx_data),
    .o_full  (w_rxFull),
    .o_empty (w_rxEmpty),
    .o_count (w_rxCount),
    .o_head  (w_rxHead)
  );

  assign w_txBusy      = (r_state == ST_DRAIN) || w_txFull;
  assign w_txIdleEmpty = (r_state == ST_IDLE) && w_txEmpty;

  always_comb begin
    w_status = 32'h0;
    w_status[STAT_TXBUSY]  = w_txBusy;
    w_status[STAT_TXEMPTY] = w_txIdleEmpty;
    w_status[STAT_RXAVAIL] = !w_rxEmpty;
    w_status[STAT_OVF]     = r_ovf;
    w_status[STAT_RXOVF]   = r_rxOvf;
    w_status[STAT_RXCNT +: 8] = 8'(w_rxCount);
  end

  always_comb begin
    w_rdData = 32'h0;
    case (abus[3:0])
      OFF_DATA:   if (!w_rxEmpty) w_rdData[7:0] = w_rxHead;
      OFF_STATUS: w_rdData = w_status;
      OFF_CTRL:   w_rdData[1:0] = r_ctrl;
      default:    w_rdData = 32'h0;
    endcase
  end

  assign dbus_out = (w_sel && m_rw) ? w_rdData : 32'hzzzz_zzzz;
  assign tx_valid = !w_txEmpty;
  assign rx_ready = !w_rxFull;
  assign irq      = r_irq;

endmodule

// File: tb/tb_cpu0_io_responder.sv
// Scoreboard bench: stimulus tasks queue expected TX bytes and bus/pin values;
// independent monitors pop and compare them when the DUT presents them.
module tb_cpu0_io_responder;
  import cpu0_io_pkg::*;

  localparam int SIG_DBUS     = 0;
  localparam int SIG_IRQ      = 1;
  localparam int SIG_TXVALID  = 2;
  localparam int SIG_RXREADY  = 3;
  localparam int SIG_RELEASED = 4;

  localparam logic [31:0] BASE_ADDR   = 32'h0008_0000;
  localparam logic [31:0] ADDR_DATA   = BASE_ADDR | 32'(OFF_DATA);
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR | 32'(OFF_STATUS);
  localparam logic [31:0] ADDR_CTRL   = BASE_ADDR | 32'(OFF_CTRL);

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } probe_t;

  typedef struct {
    logic [7:0] data;
    bit         follow;
  } txExp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        mEn, mRw;
  logic [1:0]  mSize;
  logic [31:0] abus, dbusIn;
  wire  [31:0] dbusOut;
  logic [7:0]  txData;
  logic        txValid, txReady;
  logic [7:0]  rxData;
  logic        rxValid, rxReady, irq;

  int     checks = 0;
  int     errors = 0;
  int     cycle = 0;
  int     lastBeat = -10;
  bit     sampleReq = 1'b0;
  probe_t probeQ[$];
  txExp_t txQ[$];

  cpu0_io_responder #(.BASE(32'h0008_0000), .TX_DEPTH(16), .RX_DEPTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .m_en     (mEn),
    .m_rw     (mRw),
    .m_size   (mSize),
    .abus     (abus),
    .dbus_in  (dbusIn),
    .dbus_out (dbusOut),
    .tx_data  (txData),
    .tx_valid (txValid),
    .tx_ready (txReady),
    .rx_data  (rxData),
    .rx_valid (rxValid),
    .rx_ready (rxReady),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // TX monitor: every accepted byte must be the next queued one, in order.
  always @(negedge clock) begin
    txExp_t e;
    if (txValid && txReady) begin
      checks++;
      if (txQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL txByte: got %02h, expected no byte", txData);
      end else begin
        e = txQ.pop_front();
        if (txData !== e.data) begin
          errors++;
          $display("[TB] FAIL txByte: got %02h, expected %02h", txData, e.data);
        end else if (e.follow && lastBeat != cycle - 1) begin
          errors++;
          $display("[TB] FAIL txGap: byte %02h came %0d cycles after previous, expected 1",
                   txData, cycle - lastBeat);
        end
      end
      lastBeat = cycle;
    end
  end

  always @(negedge clock) begin
    probe_t      p;
    logic [31:0] act;
    bit          ok;
    if (sampleReq) begin
      checks++;
      if (probeQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL probeQueue: got a sample request, expected a queued entry");
      end else begin
        p = probeQ.pop_front();
        case (p.sig)
          SIG_IRQ:     act = {31'h0, irq};
          SIG_TXVALID: act = {31'h0, txValid};
          SIG_RXREADY: act = {31'h0, rxReady};
          default:     act = dbusOut;
        endcase
        if (p.sig == SIG_RELEASED)
          ok = (dbusOut === 32'hzzzz_zzzz) || (dbusOut === 32'h0);
        else
          ok = (act === p.exp);
        if (!ok) begin
          errors++;
          $display("[TB] FAIL %s: got %08h, expected %08h", p.name, act, p.exp);
        end
      end
    end
  end

  task automatic checkOutput(input int sig, input logic [31:0] exp, input string name);
    probe_t p;
    p.name = name;
    p.sig  = sig;
    p.exp  = exp;
    probeQ.push_back(p);
    sampleReq = 1'b1;
    @(negedge clock);
    #1 sampleReq = 1'b0;
  endtask

  task automatic expectTx(input logic [7:0] data, input bit follow);
    txExp_t e;
    e.data   = data;
    e.follow = follow;
    txQ.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    @(posedge clock);
    #1 mEn = 1'b1; mRw = 1'b0; abus = addr; dbusIn = data; mSize = size;
    @(posedge clock);
    #1 mEn = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, input int hold, input logic [31:0] exp, input string name);
    @(posedge clock);
    #1 mEn = 1'b1; mRw = 1'b1; abus = addr;
    checkOutput(SIG_DBUS, exp, name);
    repeat (hold) @(posedge clock);
    #1 mEn = 1'b0; mRw = 1'b0;
  endtask

  task automatic rxPush(input logic [7:0] b);
    @(posedge clock);
    #1 rxValid = 1'b1; rxData = b;
    @(posedge clock);
    #1 rxValid = 1'b0;
  endtask

  task automatic applyStimulus;
    // Reset state, with the bus idle but pointing at STATUS.
    repeat (2) @(posedge clock);
    checkOutput(SIG_RELEASED, 32'h0, "rstBus");
    checkOutput(SIG_TXVALID, 32'h0, "rstTxValid");
    checkOutput(SIG_RXREADY, 32'h1, "rstRxReady");
    checkOutput(SIG_IRQ, 32'h0, "rstIrq");
    @(posedge clock);
    #1 reset = 1'b0;
    busRead(ADDR_STATUS, 1, 32'h0000_0002, "statusReset");

    // Word store, all bytes non-zero, streamed back-to-back.
    txReady = 1'b1;
    expectTx(8'h41, 1'b0); expectTx(8'h42, 1'b1); expectTx(8'h43, 1'b1); expectTx(8'h44, 1'b1);
    busWrite(ADDR_DATA, 32'h4443_4241, SZ_INT32);
    idle(8);
    busRead(ADDR_STATUS, 1, 32'h0000_0002, "statusTxDone");

    // Zero bytes skipped for multi-byte sizes, kept for BYTE; size limits lanes.
    expectTx(8'h48, 1'b0); expectTx(8'h21, 1'b0);
    busWrite(ADDR_DATA, 32'h0021_0048, SZ_INT32);
    idle(8);
    expectTx(8'h00, 1'b0);
    busWrite(ADDR_DATA, 32'h0000_0000, SZ_BYTE);
    idle(4);
    expectTx(8'h32, 1'b0); expectTx(8'h31, 1'b1);
    busWrite(ADDR_DATA, 32'h7766_3132, SZ_INT16);
    idle(6);
    expectTx(8'h52, 1'b0); expectTx(8'h51, 1'b1);
    busWrite(ADDR_DATA, 32'h9900_5152, SZ_INT24);
    idle(6);

    // Back-pressure: 16 bytes fill TX, the 17th stalls in DRAIN.
    txReady = 1'b0;
    for (int i = 0; i < 17; i++) begin
      expectTx(8'h60 + 8'(i), 1'b0);
      busWrite(ADDR_DATA, {24'h0, 8'h60 + 8'(i)}, SZ_BYTE);
    end
    busRead(ADDR_STATUS, 1, 32'h0000_0001, "statusTxBusy");
    busWrite(ADDR_DATA, 32'hAABB_CCDD, SZ_INT32);
    busRead(ADDR_STATUS, 1, 32'h0000_0009, "statusOvfSet");
    busWrite(ADDR_STATUS, 32'h0000_0008, SZ_INT32);
    busRead(ADDR_STATUS, 1, 32'h0000_0001, "statusOvfClr");
    txReady = 1'b1;
    idle(25);
    busRead(ADDR_STATUS, 1, 32'h0000_0002, "statusDrained");

    // RX path: each 2-cycle DATA read pops exactly once, empty reads 0.
    rxPush(8'h10); rxPush(8'h20); rxPush(8'h30);
    busRead(ADDR_STATUS, 1, 32'h0000_0306, "statusRx3");
    busRead(ADDR_DATA, 2, 32'h0000_0010, "rxRead0");
    busRead(ADDR_DATA, 2, 32'h0000_0020, "rxRead1");
    busRead(ADDR_DATA, 2, 32'h0000_0030, "rxRead2");
    busRead(ADDR_DATA, 2, 32'h0000_0000, "rxReadEmpty");
    busRead(ADDR_STATUS, 1, 32'h0000_0002, "statusRxEmpty");

    // RX full, RXOVF and the registered interrupt.
    busWrite(ADDR_CTRL, 32'h0000_0001, SZ_INT32);
    checkOutput(SIG_IRQ, 32'h0, "irqIdle");
    busRead(ADDR_CTRL, 1, 32'h0000_0001, "ctrlRead");
    rxPush(8'h55);
    checkOutput(SIG_IRQ, 32'h0, "irqNotYet");
    checkOutput(SIG_IRQ, 32'h1, "irqRise");
    for (int i = 1; i < 8; i++) rxPush(8'h55 + 8'(i));
    checkOutput(SIG_RXREADY, 32'h0, "rxFull");
    rxPush(8'hEE);
    busRead(ADDR_STATUS, 1, 32'h0000_0816, "statusRxOvf");
    for (int i = 0; i < 8; i++) busRead(ADDR_DATA, 1, 32'h55 + 32'(i), "rxFullRead");
    busRead(ADDR_STATUS, 1, 32'h0000_0012, "statusRxDrained");
    busWrite(ADDR_STATUS, 32'h0000_0010, SZ_INT32);
    busRead(ADDR_STATUS, 1, 32'h0000_0002, "statusRxOvfClr");
    idle(2);
    checkOutput(SIG_IRQ, 32'h0, "irqRxClear");
    busWrite(ADDR_CTRL, 32'h0000_0002, SZ_INT32);
    idle(2);
    checkOutput(SIG_IRQ, 32'h1, "irqTxEmpty");
    busWrite(ADDR_CTRL, 32'h0000_0001, SZ_INT32);

    // Reset mid-drain clears everything immediately; staged bytes are lost.
    rxPush(8'h77);
    idle(2);
    checkOutput(SIG_IRQ, 32'h1, "irqPreReset");
    txReady = 1'b0;
    busWrite(ADDR_DATA, 32'h0403_0201, SZ_INT32);
    @(posedge clock);
    #1;
    checkOutput(SIG_TXVALID, 32'h1, "txValidDrain");
    @(posedge clock);
    #1 reset = 1'b1;
    checkOutput(SIG_TXVALID, 32'h0, "txValidAsyncRst");
    checkOutput(SIG_IRQ, 32'h0, "irqAsyncRst");
    checkOutput(SIG_RXREADY, 32'h1, "rxReadyAsyncRst");
    @(posedge clock);
    #1 reset = 1'b0;
    txReady = 1'b1;
    busRead(ADDR_STATUS, 1, 32'h0000_0002, "statusPostRst");
    busRead(ADDR_CTRL, 1, 32'h0000_0000, "ctrlPostRst");
    busRead(BASE_ADDR | 32'h0000_000C, 1, 32'h0000_0000, "unmappedOff");
    idle(6);

    // Unaddressed read aliasing STATUS must leave the bus released.
    @(posedge clock);
    #1 mEn = 1'b1; mRw = 1'b1; abus = 32'h0000_0104;
    checkOutput(SIG_RELEASED, 32'h0, "unaddrBus");
    @(posedge clock);
    #1 mEn = 1'b0; mRw = 1'b0;
    idle(4);
  endtask

  initial begin
    reset = 1'b1;
    mEn = 1'b0; mRw = 1'b0; mSize = SZ_BYTE;
    abus = ADDR_STATUS; dbusIn = 32'h0;
    txReady = 1'b0; rxValid = 1'b0; rxData = 8'h0;
    applyStimulus();
    checks++;
    if (txQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL txPending: got %0d bytes still owed, expected 0", txQ.size());
    end
    checks++;
    if (probeQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL probePending: got %0d unchecked probes, expected 0", probeQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu0_io_responder.md
Name: cpu0_io_responder

Overview:
- Memory-mapped I/O responder on the cpu0 data bus. It is the target side of the cpu0 m_en/m_rw/m_size/abus/dbus protocol for the I/O window at IOADDR.
- Sits beside memory0, and its dbus_out is tri-stated onto the same dbus.
- Turns CPU byte/word stores into a byte stream on a valid/ready TX port, and buffers an incoming valid/ready RX byte stream for CPU loads.
- Raises a level interrupt on RX-available or TX-drained.

Parameters:
BASE, 'h80000, I/O window base; decode is abus[31:4]==BASE[31:4].
TX_DEPTH, 16, TX FIFO depth in bytes (power of two, >=4).
RX_DEPTH, 8, RX FIFO depth in bytes (power of two, >=2).

Ports:
clock  in  1  system clock, posedge.
reset  in  1  asynchronous, active-high reset.
m_en  in  1  bus access enable from cpu0.
m_rw  in  1  1 = read, 0 = write.
m_size  in  2  00 BYTE, 01 INT16, 10 INT24, 11 INT32.
abus  in  32  address (cpu0 mar).
dbus_in  in  32  write data (cpu0 mdr).
dbus_out  out  32  read data; 32'hZZZZZZZZ unless this block is addressed and read.
tx_data  out  8  outgoing byte.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  sink accepts the byte when tx_valid & tx_ready at posedge.
rx_data  in  8  incoming byte.
rx_valid  in  1  rx_data valid.
rx_ready  out  1  equals !rx_full.
irq  out  1  level interrupt.

Behaviour:
- **Register map** (offset = abus[3:0]):
  - 0x0 DATA.
  - 0x4 STATUS.
  - 0x8 CTRL.
  - Any other offset reads 0; writes to it are ignored.
- **Access detection:** sel = m_en & decode hit. acc_d is a register holding sel from the previous cycle.
  - Access start = sel & !acc_d.
  - Access end = !sel & acc_d.
  - Each access produces exactly one side effect, however long m_en is held.
- **Reads are combinational:** dbus_out = {24'h0, RX head} / STATUS / CTRL while sel & m_rw. Otherwise dbus_out is Z. m_size is ignored on reads.
- **DATA read:**
  - The RX pop is deferred to the access end, so data stays stable while cpu0 samples it.
  - If RX is empty: returns 0 and no pop.
- **DATA write:** at access start, if the staging register is idle, it captures dbus_in and m_size.
  - BYTE: emits byte[7:0] unconditionally (a zero byte is emitted).
  - INT16/INT24/INT32: emits bytes in order [7:0], [15:8], [23:16], [31:24], limited by size. Zero bytes are skipped.
  - The staging FSM is IDLE -> DRAIN -> IDLE. It pushes one byte per cycle while TX is not full and stalls while TX is full. It returns to IDLE after the last byte.
  - A write arriving while the FSM is in DRAIN is dropped and sets OVF (sticky).
- **STATUS read:**
  - bit0 TXBUSY = DRAIN or tx_full.
  - bit1 TXEMPTY = IDLE & tx_empty.
  - bit2 RXAVAIL = !rx_empty.
  - bit3 OVF.
  - bit4 RXOVF (rx_valid while rx_full; byte discarded).
  - [15:8] rx_count.
- **STATUS write:** bits 3 and 4 are write-1-to-clear.
- **CTRL:** read/write. bit0 RXIE, bit1 TXIE. Other bits read 0.
- **irq** is registered: irq <= (RXIE & RXAVAIL) | (TXIE & TXEMPTY).
- **TX port:** tx_valid = !tx_empty and tx_data = TX head. Pop on tx_valid & tx_ready.
  - A simultaneous push and pop on a full TX FIFO is not allowed; the push waits a cycle.
- **RX port:** push on rx_valid & rx_ready.
  - A simultaneous push and pop on a full RX FIFO is allowed only for the pop; the push is refused that cycle because rx_ready is low.
  - Push and pop in the same cycle with RX neither empty nor full keeps the count unchanged.
- FIFO pointers wrap modulo depth. Counts are log2(depth)+1 bits wide.
- **Reset** (asynchronous):
  - FIFOs empty, FSM IDLE, acc_d=0.
  - CTRL=0, OVF=RXOVF=0, irq=0.
  - tx_valid=0, rx_ready=1, dbus_out=Z.
- **Reset mid-drain** discards the staged bytes and the FIFO contents.

Decomposition:
- **Package cpu0_io_pkg:**
  - size codes (BYTE/INT16/INT24/INT32, identical to cpu0);
  - register offsets;
  - STATUS/CTRL bit positions;
  - FSM state enum.
- **Sub-module cpu0_io_fifo:** synchronous FIFO (WIDTH=8, DEPTH), with push/pop/full/empty/count/head. Instantiated twice, once for TX and once for RX.

Test Plan:
1. **Word store, all bytes non-zero:** INT32 write 0x44434241 to DATA with tx_ready=1 -> tx_data sequence 41,42,43,44 on consecutive cycles; TXEMPTY=1 afterward.
2. **Word store with zero bytes:** INT32 write 0x00210048 -> only 48,21 emitted. BYTE write 0x00 -> single 00 emitted.
3. **Back-pressure and overflow:** tx_ready=0, 17 BYTE writes (TX_DEPTH=16) -> TXBUSY=1. Next INT32 write while in DRAIN -> dropped, OVF=1. Writing 0x8 to STATUS clears OVF.
4. **RX path:** push 3 bytes 0x10,0x20,0x30 -> STATUS[15:8]=3, RXAVAIL=1. Three DATA reads, each holding m_en for 2 cycles -> 0x10,0x20,0x30, each popped once. A fourth read -> 0, no underflow.
5. **RX full and interrupt:** with RXIE=1, irq rises one cycle after the first RX byte. Fill 8 bytes -> rx_ready=0; a 9th rx_valid -> RXOVF=1 and the data is discarded.
6. **Reset mid-drain:** assert reset during DRAIN of an INT32 -> tx_valid=0 immediately (asynchronous), FIFOs empty, irq=0. Unaddressed bus access (abus=0x100) -> dbus_out stays Z.
